// File: rtl/stage_sequencer.sv
`timescale 1ns/1ps
// stage_sequencer
//   Runs up to NUM_STAGES programmed cook stages in order. For each stage it
//   loads a BCD mm:ss value into an external countdown timer, enables the
//   timer until it reports zero, and then drives the buzzer for BEEP_TICKS
//   ticks of tick_10ms. A stage programmed as 0000 is skipped without a beep.
//
//   Ports
//     clk, reset          5 MHz clock, asynchronous active-low reset
//     tick_10ms           one-cycle enable, once per 10 ms (beep timing)
//     prog_wr/idx/time    stage programming, accepted only in IDLE with valid BCD
//     prog_count          number of active stages (clamped to NUM_STAGES)
//     start/pause/abort   one-cycle control requests
//     timer_done          countdown reached zero
//     load_timer/value    one-cycle load of the countdown timer
//     timer_enable        countdown run enable
//     stage_idx           current stage
//     busy/paused/buzzer/all_done  status, decoded from registered state
module stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int BEEP_TICKS = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_10ms,
    input  logic        prog_wr,
    input  logic [1:0]  prog_idx,
    input  logic [15:0] prog_time,
    input  logic [2:0]  prog_count,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    input  logic        timer_done,
    output logic        load_timer,
    output logic [15:0] load_value,
    output logic        timer_enable,
    output logic [1:0]  stage_idx,
    output logic        busy,
    output logic        paused,
    output logic        buzzer,
    output logic        all_done
);

    localparam int               CNT_W    = (BEEP_TICKS < 1) ? 1 : $clog2(BEEP_TICKS + 1);
    localparam logic [2:0]       NS       = 3'(NUM_STAGES);
    localparam logic [CNT_W-1:0] BEEP_MAX = CNT_W'(BEEP_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSED,
        BEEP,
        FINISHED
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stage_q [4];
    logic [15:0]      cur_time;
    logic [2:0]       eff_count;
    logic             last_stage;
    logic             time_ok;
    logic             write_ok;

    // mm:ss BCD: tens digits 0-5, unit digits 0-9
    assign time_ok = (prog_time[15:12] <= 4'd5) && (prog_time[11:8] <= 4'd9) &&
                     (prog_time[7:4]   <= 4'd5) && (prog_time[3:0]  <= 4'd9);
    assign write_ok   = prog_wr && (state_q == IDLE) && time_ok && ({1'b0, prog_idx} < NS);
    assign eff_count  = (prog_count > NS) ? NS : prog_count;
    // ">=" rather than "==" so a shrinking prog_count mid-run still ends the sequence
    assign last_stage = (({1'b0, idx_q} + 3'd1) >= eff_count);
    assign cur_time   = stage_q[idx_q];

    // Entries at or above NUM_STAGES are never written and stay at 0000.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                stage_q[i] <= '0;
            end
        end else if (write_ok) begin
            stage_q[prog_idx] <= prog_time;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (eff_count != 3'd0)) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end
                end
                LOAD: begin
                    if (cur_time == 16'h0000) begin
                        if (last_stage) begin
                            state_d = FINISHED;
                        end else begin
                            state_d = LOAD;
                            idx_d   = idx_q + 2'd1;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (timer_done) begin
                        state_d = BEEP;
                        cnt_d   = '0;
                    end else if (pause) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (pause) begin
                        state_d = RUN;
                    end
                end
                BEEP: begin
                    if (cnt_q == BEEP_MAX) begin
                        if (last_stage) begin
                            state_d = FINISHED;
                        end else begin
                            state_d = LOAD;
                            idx_d   = idx_q + 2'd1;
                        end
                    end else if (tick_10ms) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FINISHED: begin
                    if (start) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        load_timer   = (state_q == LOAD);
        load_value   = (state_q == LOAD) ? cur_time : 16'h0000;
        timer_enable = (state_q == RUN);
        stage_idx    = idx_q;
        busy         = (state_q == LOAD) || (state_q == RUN) ||
                       (state_q == PAUSED) || (state_q == BEEP);
        paused       = (state_q == PAUSED);
        buzzer       = (state_q == BEEP);
        all_done     = (state_q == FINISHED);
    end

endmodule

// File: tb/tb_stage_sequencer.sv
`timescale 1ns/1ps
module tb_stage_sequencer;

    logic        clk;
    logic        reset;
    logic        tick_10ms;
    logic        prog_wr;
    logic [1:0]  prog_idx;
    logic [15:0] prog_time;
    logic [2:0]  prog_count;
    logic        start;
    logic        pause;
    logic        abort;
    logic        timer_done;
    logic        load_timer;
    logic [15:0] load_value;
    logic        timer_enable;
    logic [1:0]  stage_idx;
    logic        busy;
    logic        paused;
    logic        buzzer;
    logic        all_done;

    int errors = 0;
    int checks = 0;
    int tick_div = 0;

    stage_sequencer #(.NUM_STAGES(4), .BEEP_TICKS(50)) dut (
        .clk(clk), .reset(reset), .tick_10ms(tick_10ms),
        .prog_wr(prog_wr), .prog_idx(prog_idx), .prog_time(prog_time),
        .prog_count(prog_count), .start(start), .pause(pause), .abort(abort),
        .timer_done(timer_done), .load_timer(load_timer), .load_value(load_value),
        .timer_enable(timer_enable), .stage_idx(stage_idx), .busy(busy),
        .paused(paused), .buzzer(buzzer), .all_done(all_done)
    );

    // 5 MHz clock
    initial begin
        clk = 1'b0;
        forever #100 clk = ~clk;
    end

    // tick_10ms compressed to one pulse every 4 clocks, updated just after posedge
    initial begin
        tick_10ms = 1'b0;
        forever begin
            @(posedge clk);
            #5;
            tick_10ms = (tick_div == 3);
            tick_div  = (tick_div + 1) % 4;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // inputs change and outputs are sampled at negedge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic prog(input logic [1:0] i, input logic [15:0] t);
        prog_wr = 1'b1; prog_idx = i; prog_time = t;
        cyc(1);
        prog_wr = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // counts ticks consumed while buzzer is high; returns on the first cycle with buzzer low
    task automatic count_beep(output int ticks, output bit timeout);
        ticks = 0;
        timeout = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if (!buzzer) begin
                timeout = 1'b0;
                break;
            end
            if (tick_10ms) ticks++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        cyc(2);
        checks++; if ({load_timer, timer_enable, busy, paused, buzzer, all_done} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000",
                {load_timer, timer_enable, busy, paused, buzzer, all_done});
        end
        checks++; if (load_value !== 16'h0000) begin
            errors++; $display("FAIL reset_load_value: got %h want 0000", load_value);
        end
        checks++; if (stage_idx !== 2'd0) begin
            errors++; $display("FAIL reset_stage_idx: got %0d want 0", stage_idx);
        end
        reset = 1'b1;
        cyc(1);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_invalid_write;
        prog(2'd0, 16'h0075);
        prog(2'd0, 16'h6000);
        prog(2'd1, 16'h000A);
        prog_count = 3'd2;
        pulse_start;
        checks++; if (load_timer !== 1'b1 || load_value !== 16'h0000) begin
            errors++; $display("FAIL bad_write_stage0: got load=%b value=%h want 1/0000", load_timer, load_value);
        end
        cyc(1);
        checks++; if (load_timer !== 1'b1 || load_value !== 16'h0000 || stage_idx !== 2'd1) begin
            errors++; $display("FAIL bad_write_stage1: got load=%b value=%h idx=%0d want 1/0000/1",
                load_timer, load_value, stage_idx);
        end
        cyc(1);
        checks++; if (all_done !== 1'b1 || buzzer !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL skip_to_finished: got done=%b buzz=%b busy=%b want 1/0/0", all_done, buzzer, busy);
        end
        pulse_start;
        checks++; if (all_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL finished_start_idle: got done=%b busy=%b want 0/0", all_done, busy);
        end
    endtask

    task automatic test_two_stage;
        int  ticks;
        bit  tmo;
        prog(2'd0, 16'h0005);
        prog(2'd1, 16'h0003);
        prog_count = 3'd2;
        pulse_start;
        checks++; if (load_timer !== 1'b1 || load_value !== 16'h0005 || stage_idx !== 2'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL load_stage0: got load=%b value=%h idx=%0d busy=%b want 1/0005/0/1",
                load_timer, load_value, stage_idx, busy);
        end
        cyc(1);
        checks++; if (timer_enable !== 1'b1 || load_timer !== 1'b0) begin
            errors++; $display("FAIL run_stage0: got en=%b load=%b want 1/0", timer_enable, load_timer);
        end
        prog(2'd1, 16'h0009);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        checks++; if (timer_enable !== 1'b1 || load_timer !== 1'b0) begin
            errors++; $display("FAIL start_ignored_run: got en=%b load=%b want 1/0", timer_enable, load_timer);
        end
        timer_done = 1'b1;
        cyc(1);
        timer_done = 1'b0;
        checks++; if (buzzer !== 1'b1 || timer_enable !== 1'b0) begin
            errors++; $display("FAIL beep_stage0: got buzz=%b en=%b want 1/0", buzzer, timer_enable);
        end
        count_beep(ticks, tmo);
        checks++; if (tmo !== 1'b0 || ticks !== 50) begin
            errors++; $display("FAIL beep0_ticks: got ticks=%0d timeout=%b want 50/0", ticks, tmo);
        end
        checks++; if (load_timer !== 1'b1 || load_value !== 16'h0003 || stage_idx !== 2'd1) begin
            errors++; $display("FAIL load_stage1: got load=%b value=%h idx=%0d want 1/0003/1",
                load_timer, load_value, stage_idx);
        end
        cyc(1);
        timer_done = 1'b1;
        cyc(1);
        timer_done = 1'b0;
        count_beep(ticks, tmo);
        checks++; if (tmo !== 1'b0 || ticks !== 50) begin
            errors++; $display("FAIL beep1_ticks: got ticks=%0d timeout=%b want 50/0", ticks, tmo);
        end
        checks++; if (all_done !== 1'b1 || buzzer !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL all_done: got done=%b buzz=%b busy=%b want 1/0/0", all_done, buzzer, busy);
        end
        pulse_start;
    endtask

    task automatic test_pause;
        int ticks;
        bit tmo;
        prog(2'd0, 16'h0007);
        prog(2'd1, 16'h0004);
        prog_count = 3'd2;
        pulse_start;
        cyc(1);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        checks++; if (timer_enable !== 1'b0 || paused !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL pause_enter: got en=%b paused=%b busy=%b want 0/1/1", timer_enable, paused, busy);
        end
        timer_done = 1'b1;
        start = 1'b1;
        cyc(1);
        timer_done = 1'b0;
        start = 1'b0;
        checks++; if (paused !== 1'b1 || buzzer !== 1'b0 || load_timer !== 1'b0) begin
            errors++; $display("FAIL paused_ignores: got paused=%b buzz=%b load=%b want 1/0/0", paused, buzzer, load_timer);
        end
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        checks++; if (timer_enable !== 1'b1 || paused !== 1'b0) begin
            errors++; $display("FAIL pause_resume: got en=%b paused=%b want 1/0", timer_enable, paused);
        end
        timer_done = 1'b1;
        pause = 1'b1;
        cyc(1);
        timer_done = 1'b0;
        pause = 1'b0;
        checks++; if (buzzer !== 1'b1 || paused !== 1'b0) begin
            errors++; $display("FAIL done_beats_pause: got buzz=%b paused=%b want 1/0", buzzer, paused);
        end
        count_beep(ticks, tmo);
        checks++; if (tmo !== 1'b0 || load_value !== 16'h0004 || stage_idx !== 2'd1) begin
            errors++; $display("FAIL pause_load_stage1: got value=%h idx=%0d timeout=%b want 0004/1/0",
                load_value, stage_idx, tmo);
        end
        cyc(1);
        timer_done = 1'b1;
        cyc(1);
        timer_done = 1'b0;
        cyc(3);
        checks++; if (buzzer !== 1'b1 || stage_idx !== 2'd1) begin
            errors++; $display("FAIL beep_stage1: got buzz=%b idx=%0d want 1/1", buzzer, stage_idx);
        end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || buzzer !== 1'b0 || stage_idx !== 2'd0 || timer_enable !== 1'b0 || all_done !== 1'b0) begin
            errors++; $display("FAIL abort_beep: got busy=%b buzz=%b idx=%0d en=%b done=%b want 0/0/0/0/0",
                busy, buzzer, stage_idx, timer_enable, all_done);
        end
        pulse_start;
        checks++; if (load_timer !== 1'b1 || load_value !== 16'h0007) begin
            errors++; $display("FAIL stages_retained: got load=%b value=%h want 1/0007", load_timer, load_value);
        end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || load_timer !== 1'b0) begin
            errors++; $display("FAIL abort_load: got busy=%b load=%b want 0/0", busy, load_timer);
        end
    endtask

    task automatic test_skip;
        prog(2'd0, 16'h0000);
        prog(2'd1, 16'h0010);
        prog_count = 3'd2;
        pulse_start;
        checks++; if (load_timer !== 1'b1 || load_value !== 16'h0000 || buzzer !== 1'b0) begin
            errors++; $display("FAIL skip_load0: got load=%b value=%h buzz=%b want 1/0000/0", load_timer, load_value, buzzer);
        end
        cyc(1);
        checks++; if (load_timer !== 1'b1 || load_value !== 16'h0010 || stage_idx !== 2'd1 || buzzer !== 1'b0) begin
            errors++; $display("FAIL skip_load1: got load=%b value=%h idx=%0d buzz=%b want 1/0010/1/0",
                load_timer, load_value, stage_idx, buzzer);
        end
        cyc(1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        prog(2'd0, 16'h0001);
        prog_count = 3'd1;
        pulse_start;
        cyc(1);
        checks++; if (timer_enable !== 1'b1) begin
            errors++; $display("FAIL pre_reset_run: got en=%b want 1", timer_enable);
        end
        #20;
        reset = 1'b0;
        #1;
        checks++; if ({load_timer, timer_enable, busy, paused, buzzer, all_done} !== 6'b0 ||
                      load_value !== 16'h0000 || stage_idx !== 2'd0) begin
            errors++; $display("FAIL async_reset_run: got flags=%b value=%h idx=%0d want 000000/0000/0",
                {load_timer, timer_enable, busy, paused, buzzer, all_done}, load_value, stage_idx);
        end
        cyc(1);
        reset = 1'b1;
        prog(2'd0, 16'h0001);
        pulse_start;
        cyc(1);
        timer_done = 1'b1;
        cyc(1);
        timer_done = 1'b0;
        cyc(2);
        #20;
        reset = 1'b0;
        #1;
        checks++; if (buzzer !== 1'b0 || busy !== 1'b0 || load_timer !== 1'b0) begin
            errors++; $display("FAIL async_reset_beep: got buzz=%b busy=%b load=%b want 0/0/0", buzzer, busy, load_timer);
        end
        cyc(1);
        reset = 1'b1;
        prog_count = 3'd0;
        pulse_start;
        checks++; if (busy !== 1'b0 || load_timer !== 1'b0) begin
            errors++; $display("FAIL zero_count_start: got busy=%b load=%b want 0/0", busy, load_timer);
        end
    endtask

    initial begin
        reset = 1'b0;
        prog_wr = 1'b0; prog_idx = 2'd0; prog_time = 16'h0000; prog_count = 3'd0;
        start = 1'b0; pause = 1'b0; abort = 1'b0; timer_done = 1'b0;
        test_reset;
        test_invalid_write;
        test_two_stage;
        test_pause;
        test_skip;
        test_reset_mid_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
